alu_entry_seq: RTL and testbench
================================

# alu_entry_seq

Operand/opcode entry sequencer sitting directly upstream of the ALU board wrapper. It debounces the raw push-buttons and walks the user through entering operand A, operand B and the ALU opcode from the slide switches. It then presents a stable, registered operand set with a one-cycle valid strobe to the ALU and its hex-display stage.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- WORD_W, 32: ALU operand width.
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- KEY  input  4  raw push-buttons, active-low (pressed = 0); KEY[0] = enter, KEY[1] = clear, KEY[3:2] ignored.
- SW  input  18  raw slide switches; SW[15:0] = operand value, SW[17] = sign-extend select, SW[3:0] = opcode during opcode stage.
- port_a  output  WORD_W  latched operand A.
- port_b  output  WORD_W  latched operand B.
- op  output  4  latched ALU opcode.
- entry_valid  output  1  one-cycle pulse: new operand set complete.
- stage  output  2  current entry stage (entry_state_t encoding) for display.

## Operation
- Each used key passes through a 2-flop synchronizer, then a debouncer holding a debounced level (reset value 1 = released) and a stability counter.
- Counter increments while the synced level differs from the debounced level and clears to 0 whenever they match. This covers bounce back and forth.
- On the cycle the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears. A press event is a 1→0 flip, pulsing for exactly that one cycle. Releases produce no event.
- SW is sampled directly on the press-event cycle and is not synchronized. The user holds the switches steady while pressing.
- Operand capture: SW[17]=1 sign-extends SW[15:0] to WORD_W; SW[17]=0 zero-extends.
- FSM states (entry_state_t): GET_A=0, GET_B=1, GET_OP=2, SHOW=3.
  - GET_A + enter: port_a ← extended SW; go to GET_B.
  - GET_B + enter: port_b ← extended SW; go to GET_OP.
  - GET_OP + enter: op ← SW[3:0]; entry_valid ← 1; go to SHOW.
  - SHOW + enter: go to GET_A. port_a, port_b and op are retained until overwritten.
  - Any state + clear: go to GET_A; port_a, port_b and op ← 0; entry_valid stays 0.
- Enter and clear press events in the same cycle: clear wins.
- entry_valid is registered and cleared every cycle it is not being set.
- Reset values: state = GET_A, stage = 0, port_a = port_b = 0, op = 0, entry_valid = 0. Both debounced levels = 1, both counters = 0, synchronizers = 1.
- Reset asserted mid-entry or mid-debounce aborts everything immediately, with no output glitch beyond the return to reset values.

## Timing
- Raw key edge at cycle t, held stable: the synced level differs from cycle t+2. The press event and register/state update land on the edge at t+2+DEBOUNCE_CYCLES−1.
- entry_valid is high exactly in the first cycle the state reads SHOW. op, port_a and port_b are already valid in that cycle.
- Outputs are all registered; none depends combinationally on KEY or SW.
- One press produces exactly one advance, however long the key is held.

## Structure
- Shared package types_pkg gains entry_state_t (2-bit enum, values above) and the opcode width constant.
- Sub-module key_debounce (synchronizer, counter and debounced level, press-event output), parameterized by DEBOUNCE_CYCLES. Instantiated twice, for KEY[0] and KEY[1].
- Counter width is $clog2(DEBOUNCE_CYCLES+1).
- The top-level holds the FSM and capture registers only.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset: hold RST high mid-count. Expect all outputs 0, stage=0; after release, no spurious event.
- Clean sequence:
  - SW=0x00005, press/release enter → port_a=5.
  - SW=0x00003 → port_b=3.
  - SW[3:0]=0x2 → op=2, entry_valid high one cycle, stage=3.
- Sign extension: SW[17]=1, SW[15:0]=0x8001, enter in GET_A → port_a=0xFFFF8001. With SW[17]=0 → port_a=0x00008001.
- Bounce: KEY[0] toggles 0/1/0 at 2-cycle spacing, then holds 0 → exactly one advance, landing 5 cycles after the final stable edge. Holding 0 for 100 cycles gives no further advance.
- Clear: in GET_OP, press clear → stage=0, port_a=port_b=op=0, entry_valid never asserted. Enter and clear debounced in the same cycle → clear behaviour.
- Wrap: from SHOW press enter → GET_A with the previous port_a/port_b/op still present. entry_valid stays 0 until the next opcode capture.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types and constants for the ALU board front end.
package types_pkg;

  localparam int unsigned OP_W      = 4;   // ALU opcode width
  localparam int unsigned OPERAND_W = 16;  // operand bits taken from the slide switches
  localparam int unsigned KEY_W     = 4;   // push-button bank width
  localparam int unsigned SW_W      = 18;  // slide-switch bank width

  // Operand entry stage; the encoding is shown directly on the display.
  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    SHOW   = 2'd3
  } entry_state_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and debounced
// level, with a one-cycle press event on each accepted 1->0 level change.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   key_raw  raw active-low button input
//   press_c  press event, high for the single cycle the debounced level falls
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flip_c;

  // Synchronizer; idles at the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Counter restarts on any return to the debounced level, so bounce never accumulates.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip_c  = 1'b0;
    if (sync_q2 == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      flip_c  = 1'b1;
      level_d = sync_q2;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounced level and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only presses (falling debounced level) generate an event.
  assign press_c = flip_c & ~sync_q2;

endmodule

// File: rtl/alu_entry_seq.sv
// Operand/opcode entry sequencer: debounces enter/clear, steps through
// operand A, operand B and opcode capture, then strobes entry_valid.
// Ports:
//   CLK, RST     clock and asynchronous active-high reset
//   KEY[3:0]     raw active-low buttons; [0] enter, [1] clear, [3:2] unused
//   SW[17:0]     raw switches; [15:0] operand, [17] sign-extend, [3:0] opcode
//   port_a/b     latched operands (WORD_W)
//   op           latched opcode
//   entry_valid  one-cycle pulse on entering SHOW
//   stage        current entry stage
module alu_entry_seq
  import types_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned WORD_W          = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [KEY_W-1:0]  KEY,
  input  logic [SW_W-1:0]   SW,
  output logic [WORD_W-1:0] port_a,
  output logic [WORD_W-1:0] port_b,
  output logic [OP_W-1:0]   op,
  output logic              entry_valid,
  output logic [1:0]        stage
);

  entry_state_t      state_q;
  entry_state_t      state_d;
  logic [WORD_W-1:0] port_a_d;
  logic [WORD_W-1:0] port_b_d;
  logic [OP_W-1:0]   op_d;
  logic              entry_valid_d;
  logic              enter_c;
  logic              clear_c;
  logic [WORD_W-1:0] operand_c;
  logic              unused_inputs;

  assign unused_inputs = ^{KEY[3:2], SW[16]};

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk     (CLK),
    .rst     (RST),
    .key_raw (KEY[0]),
    .press_c (enter_c)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk     (CLK),
    .rst     (RST),
    .key_raw (KEY[1]),
    .press_c (clear_c)
  );

  // Switch operand, sign- or zero-extended; SW is only consumed on a press cycle.
  assign operand_c = {{(WORD_W - OPERAND_W){SW[17] & SW[15]}}, SW[OPERAND_W-1:0]};

  // Next-state and capture logic; clear has priority over enter.
  always_comb begin
    state_d       = state_q;
    port_a_d      = port_a;
    port_b_d      = port_b;
    op_d          = op;
    entry_valid_d = 1'b0;
    if (clear_c) begin
      state_d  = GET_A;
      port_a_d = '0;
      port_b_d = '0;
      op_d     = '0;
    end else if (enter_c) begin
      unique case (state_q)
        GET_A: begin
          port_a_d = operand_c;
          state_d  = GET_B;
        end
        GET_B: begin
          port_b_d = operand_c;
          state_d  = GET_OP;
        end
        GET_OP: begin
          op_d          = SW[OP_W-1:0];
          entry_valid_d = 1'b1;
          state_d       = SHOW;
        end
        SHOW: begin
          state_d = GET_A;
        end
        default: begin
          state_d = GET_A;
        end
      endcase
    end
  end

  // State and capture registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= GET_A;
      port_a      <= '0;
      port_b      <= '0;
      op          <= '0;
      entry_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_a      <= port_a_d;
      port_b      <= port_b_d;
      op          <= op_d;
      entry_valid <= entry_valid_d;
    end
  end

  assign stage = state_q;

endmodule

// File: tb/tb_alu_entry_seq.sv
// Scoreboard bench for alu_entry_seq with DEBOUNCE_CYCLES=4. Every change of
// the observable output set pops one expected snapshot and is compared.
module tb_alu_entry_seq;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [1:0]  stage;
    logic        valid;
  } snap_t;

  typedef struct {
    snap_t v;
    int    cyc;   // required cycle stamp, -1 when timing is not checked
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  KEY = 4'hF;
  logic [17:0] SW  = '0;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [3:0]  op;
  logic        entry_valid;
  logic [1:0]  stage;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  bit    mon_en = 1'b0;
  snap_t prev;
  exp_t  q[$];

  alu_entry_seq #(.DEBOUNCE_CYCLES(4), .WORD_W(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .KEY         (KEY),
    .SW          (SW),
    .port_a      (port_a),
    .port_b      (port_b),
    .op          (op),
    .entry_valid (entry_valid),
    .stage       (stage)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic snap_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] o,
                               logic [1:0] s, logic v);
    snap_t r;
    r.a = a; r.b = b; r.op = o; r.stage = s; r.valid = v;
    return r;
  endfunction

  function automatic snap_t cur_snap();
    return mk(port_a, port_b, op, stage, entry_valid);
  endfunction

  task automatic push(snap_t v, int c);
    exp_t e;
    e.v = v; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Press the masked keys (bit0 enter, bit1 clear) with switches set, then release.
  task automatic press(logic [17:0] sw, logic [1:0] mask);
    SW  = sw;
    KEY = {2'b11, ~mask};
    cycles(12);
    KEY = 4'hF;
    cycles(12);
  endtask

  // Monitor: any change of the output set must match the next expected snapshot.
  always @(negedge CLK) begin
    if (mon_en) begin
      snap_t c;
      c = cur_snap();
      if (c != prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got a=%h b=%h op=%h stage=%0d valid=%b",
                   cyc, c.a, c.b, c.op, c.stage, c.valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (c != e.v || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL output_set cyc=%0d (want %0d) got a=%h b=%h op=%h stage=%0d valid=%b want a=%h b=%h op=%h stage=%0d valid=%b",
                     cyc, e.cyc, c.a, c.b, c.op, c.stage, c.valid,
                     e.v.a, e.v.b, e.v.op, e.v.stage, e.v.valid);
          end
        end
        prev = c;
      end
    end
  end

  initial begin
    int k;
    snap_t zero;
    zero = mk(32'h0, 32'h0, 4'h0, 2'd0, 1'b0);

    // Reset state
    cycles(3);
    checks++;
    if (cur_snap() != zero) begin
      errors++;
      $display("FAIL reset_state got a=%h b=%h op=%h stage=%0d valid=%b want all zero",
               port_a, port_b, op, stage, entry_valid);
    end
    RST = 1'b0;
    cycles(2);
    prev   = cur_snap();
    mon_en = 1'b1;

    // Clean sequence
    push(mk(32'h5, 32'h0, 4'h0, 2'd1, 1'b0), -1);
    press(18'h00005, 2'b01);
    push(mk(32'h5, 32'h3, 4'h0, 2'd2, 1'b0), -1);
    press(18'h00003, 2'b01);
    push(mk(32'h5, 32'h3, 4'h2, 2'd3, 1'b1), -1);
    push(mk(32'h5, 32'h3, 4'h2, 2'd3, 1'b0), -1);
    press(18'h00002, 2'b01);

    // Wrap: values retained, no strobe
    push(mk(32'h5, 32'h3, 4'h2, 2'd0, 1'b0), -1);
    press(18'h00000, 2'b01);

    // Sign extension on A, positive value with SW[17] on B
    push(mk(32'hFFFF8001, 32'h3, 4'h2, 2'd1, 1'b0), -1);
    press(18'h28001, 2'b01);
    push(mk(32'hFFFF8001, 32'h5, 4'h2, 2'd2, 1'b0), -1);
    press(18'h20005, 2'b01);

    // Clear in GET_OP
    push(zero, -1);
    press(18'h00002, 2'b10);

    // Zero extension
    push(mk(32'h00008001, 32'h0, 4'h0, 2'd1, 1'b0), -1);
    press(18'h08001, 2'b01);

    // Enter and clear together: clear wins
    push(zero, -1);
    press(18'h00007, 2'b11);

    // Bounce 0/1/0 at 2-cycle spacing, then held: one advance, exact cycle
    SW     = 18'h00007;
    KEY[0] = 1'b0;
    cycles(2);
    KEY[0] = 1'b1;
    cycles(2);
    KEY[0] = 1'b0;
    k = cyc;
    push(mk(32'h7, 32'h0, 4'h0, 2'd1, 1'b0), k + 6);
    cycles(100);
    KEY[0] = 1'b1;
    cycles(12);

    // Reset asserted mid-debounce
    KEY[0] = 1'b0;
    cycles(3);
    push(zero, -1);
    RST = 1'b1;
    cycles(1);
    KEY = 4'hF;
    cycles(3);
    RST = 1'b0;
    cycles(30);

    // Normal operation after reset
    push(mk(32'h9, 32'h0, 4'h0, 2'd1, 1'b0), -1);
    press(18'h00009, 2'b01);

    // All expectations must have been consumed
    for (int i = 0; i < 50 && q.size() != 0; i++) cycles(1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d left want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
